// File: rtl/wb_slave_dec4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_slave_dec4_pkg
//  Brief    : Shared types and constants for the 4-port Wishbone slave decoder
//  Revision : 1.0  initial release
// ============================================================================
package wb_slave_dec4_pkg;

  localparam int c_NUM_SLV = 4;
  localparam int c_IDX_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] c_ERR_NONE     = 2'b00;
  localparam logic [1:0] c_ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] c_ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] c_ERR_SLAVE    = 2'b11;

  function automatic logic [c_NUM_SLV-1:0] f_onehot(input logic [c_IDX_W-1:0] idx);
    f_onehot      = '0;
    f_onehot[idx] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_dec_tmo_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : wb_dec_tmo_cnt
//  Brief    : Slave-response watchdog; expires after TMO enabled cycles
//  Revision : 1.0  initial release
// ============================================================================
module wb_dec_tmo_cnt #(
  parameter int TMO = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int          c_CW   = 8;
  localparam logic [7:0]  c_LAST = c_CW'(TMO - 1);

  logic [c_CW-1:0] r_cnt;

  // Saturates at the terminal value so a stalled FSM never wraps the count.
  always_ff @(posedge CLK) begin
    if (RST || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/wb_slave_dec4.sv
`default_nettype none
// ============================================================================
//  Module   : wb_slave_dec4
//  Brief    : Wishbone classic 1-to-4 slave decoder with timeout and unmapped ERR.
//             Optional WB_DEC_STATUS_EN adds a sticky ERR_CODE output.
//  Revision : 1.0  initial release
// ============================================================================
module wb_slave_dec4
  import wb_slave_dec4_pkg::*;
#(
  parameter int         AW      = 32,
  parameter int         DW      = 32,
  parameter logic [3:0] SLV_MAP = 4'b1111,
  parameter int         TMO     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 M_CYC,
  input  logic                 M_STB,
  input  logic [AW-1:0]        M_ADR,
  output logic                 M_ACK,
  output logic                 M_ERR,
  output logic [DW-1:0]        M_DAT,
  output logic [c_NUM_SLV-1:0] S_STB,
  input  logic [c_NUM_SLV-1:0] S_ACK,
  input  logic [c_NUM_SLV-1:0] S_ERR,
  input  logic [DW-1:0]        S_DAT0,
  input  logic [DW-1:0]        S_DAT1,
  input  logic [DW-1:0]        S_DAT2,
  input  logic [DW-1:0]        S_DAT3,
  output logic [c_IDX_W-1:0]   SEL
`ifdef WB_DEC_STATUS_EN
  ,
  output logic [1:0]           ERR_CODE
`endif
);

  state_t              r_state;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_req;
  logic                w_sack;
  logic                w_serr;
  logic [DW-1:0]       w_sdat;
  logic                w_expire;
  logic                w_tmo_clr;
  logic                w_tmo_en;
  logic                w_adr_unused;

  assign w_idx        = M_ADR[AW-1:AW-2];
  assign w_req        = M_CYC & M_STB;
  assign w_sack       = S_ACK[SEL];
  assign w_serr       = S_ERR[SEL];
  assign w_tmo_clr    = (r_state != ST_BUSY);
  assign w_tmo_en     = (r_state == ST_BUSY);
  assign w_adr_unused = ^M_ADR[AW-3:0];

  always_comb begin
    w_sdat = S_DAT0;
    case (SEL)
      2'd1:    w_sdat = S_DAT1;
      2'd2:    w_sdat = S_DAT2;
      2'd3:    w_sdat = S_DAT3;
      default: w_sdat = S_DAT0;
    endcase
  end

  wb_dec_tmo_cnt #(
    .TMO (TMO)
  ) u_tmo (
    .CLK      (CLK),
    .RST      (RST),
    .i_clr    (w_tmo_clr),
    .i_en     (w_tmo_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      M_ACK    <= 1'b0;
      M_ERR    <= 1'b0;
      M_DAT    <= '0;
      S_STB    <= '0;
      SEL      <= '0;
`ifdef WB_DEC_STATUS_EN
      ERR_CODE <= c_ERR_NONE;
`endif
    end else begin
      M_ACK <= 1'b0;
      M_ERR <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            SEL <= w_idx;
            if (SLV_MAP[w_idx]) begin
              S_STB   <= f_onehot(w_idx);
              r_state <= ST_BUSY;
            end else begin
              M_ERR   <= 1'b1;
              r_state <= ST_RESP;
`ifdef WB_DEC_STATUS_EN
              ERR_CODE <= c_ERR_UNMAPPED;
`endif
            end
          end
        end
        // Priority: master abort, slave ERR, slave ACK, then watchdog.
        ST_BUSY: begin
          if (!M_CYC) begin
            S_STB   <= '0;
            r_state <= ST_IDLE;
          end else if (w_serr) begin
            S_STB   <= '0;
            M_ERR   <= 1'b1;
            r_state <= ST_RESP;
`ifdef WB_DEC_STATUS_EN
            ERR_CODE <= c_ERR_SLAVE;
`endif
          end else if (w_sack) begin
            S_STB   <= '0;
            M_ACK   <= 1'b1;
            M_DAT   <= w_sdat;
            r_state <= ST_RESP;
          end else if (w_expire) begin
            S_STB   <= '0;
            M_ERR   <= 1'b1;
            r_state <= ST_RESP;
`ifdef WB_DEC_STATUS_EN
            ERR_CODE <= c_ERR_TIMEOUT;
`endif
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_dec4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_slave_dec4
//  Brief    : Self-checking bench for wb_slave_dec4 (SLV_MAP=0111, TMO=16)
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_slave_dec4;

  localparam int         c_TMO = 16;
  localparam logic [3:0] c_MAP = 4'b0111;

  logic        CLK = 1'b0;
  logic        RST;
  logic        M_CYC, M_STB;
  logic [31:0] M_ADR;
  logic        M_ACK, M_ERR;
  logic [31:0] M_DAT;
  logic [3:0]  S_STB, S_ACK, S_ERR;
  logic [31:0] S_DAT0, S_DAT1, S_DAT2, S_DAT3;
  logic [1:0]  SEL;
  logic [1:0]  ERR_CODE;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_dat;
  logic [1:0]  m_code;

  always #5 CLK = ~CLK;

  wb_slave_dec4 #(.AW(32), .DW(32), .SLV_MAP(c_MAP), .TMO(c_TMO)) dut (
    .CLK(CLK), .RST(RST), .M_CYC(M_CYC), .M_STB(M_STB), .M_ADR(M_ADR),
    .M_ACK(M_ACK), .M_ERR(M_ERR), .M_DAT(M_DAT), .S_STB(S_STB),
    .S_ACK(S_ACK), .S_ERR(S_ERR), .S_DAT0(S_DAT0), .S_DAT1(S_DAT1),
    .S_DAT2(S_DAT2), .S_DAT3(S_DAT3), .SEL(SEL)
`ifdef WB_DEC_STATUS_EN
    , .ERR_CODE(ERR_CODE)
`endif
  );

`ifndef WB_DEC_STATUS_EN
  assign ERR_CODE = 2'b00;
`endif

  typedef struct {
    logic [1:0]  idx;
    int          lat;
    logic        a;
    logic        e;
    int          stb;
    int          resp;
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic [1:0]  code;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One master transfer; the slave answers in its (lat+1)-th strobe cycle.
  task automatic run_xfer(input logic [1:0] idx, input int lat, input logic a, input logic e,
                          output int stb_n, output int resp_cyc, output logic g_ack,
                          output logic g_err, output logic [31:0] g_dat,
                          output logic [1:0] g_sel, output int bad);
    logic [3:0] nz;
    logic       done;
    stb_n = 0; resp_cyc = 0; g_ack = 0; g_err = 0; g_dat = 0; g_sel = 0; bad = 0; done = 0;
    M_CYC = 1'b1; M_STB = 1'b1; M_ADR = {idx, 30'($urandom)};
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge CLK); @(negedge CLK);
      nz = 4'($urandom); nz[idx] = 1'b0; S_ACK = nz;
      nz = 4'($urandom); nz[idx] = 1'b0; S_ERR = nz;
      if (S_STB != 4'b0000) begin
        if (S_STB != (4'b0001 << idx)) bad++;
        else begin
          stb_n++;
          if (stb_n == lat + 1) begin S_ACK[idx] = a; S_ERR[idx] = e; end
        end
      end
      if (M_ACK || M_ERR) begin
        resp_cyc = c; g_ack = M_ACK; g_err = M_ERR; g_dat = M_DAT; g_sel = SEL; done = 1;
        if (S_STB != 4'b0000) bad++;
        M_CYC = 1'b0; M_STB = 1'b0; S_ACK = 4'b0; S_ERR = 4'b0;
      end
    end
    M_CYC = 1'b0; M_STB = 1'b0; S_ACK = 4'b0; S_ERR = 4'b0;
    @(posedge CLK); @(negedge CLK);
    if (M_ACK || M_ERR || S_STB != 4'b0000) bad++;
  endtask

  task automatic xfer_check(input string tag, input logic [1:0] idx, input int lat,
                            input logic a, input logic e, input int x_stb, input int x_resp,
                            input logic x_ack, input logic x_err, input logic [31:0] x_dat,
                            input logic [1:0] x_code);
    int stb_n, resp_cyc, bad;
    logic g_ack, g_err;
    logic [31:0] g_dat;
    logic [1:0] g_sel;
    run_xfer(idx, lat, a, e, stb_n, resp_cyc, g_ack, g_err, g_dat, g_sel, bad);
    chk($sformatf("%s stb_cycles", tag), 64'(stb_n), 64'(x_stb));
    chk($sformatf("%s resp_cycle", tag), 64'(resp_cyc), 64'(x_resp));
    chk($sformatf("%s ack/err", tag), {62'b0, g_ack, g_err}, {62'b0, x_ack, x_err});
    chk($sformatf("%s m_dat", tag), 64'(g_dat), 64'(x_dat));
    chk($sformatf("%s sel", tag), 64'(g_sel), 64'(idx));
    chk($sformatf("%s protocol", tag), 64'(bad), 64'd0);
`ifdef WB_DEC_STATUS_EN
    chk($sformatf("%s err_code", tag), 64'(ERR_CODE), 64'(x_code));
`else
    if (x_code === 2'bxx) $display("unreachable");
`endif
  endtask

  // Reference behaviour derived directly from the transfer rules.
  task automatic model(input logic [1:0] idx, input int lat, input logic a, input logic e,
                       input logic [31:0] sdat, output int x_stb, output int x_resp,
                       output logic x_ack, output logic x_err);
    if (!c_MAP[idx]) begin
      x_stb = 0; x_resp = 1; x_ack = 0; x_err = 1; m_code = 2'b01;
    end else if ((a || e) && lat < c_TMO) begin
      x_stb = lat + 1; x_resp = lat + 2; x_ack = a && !e; x_err = e;
      if (x_ack) m_dat = sdat;
      if (x_err) m_code = 2'b11;
    end else begin
      x_stb = c_TMO; x_resp = c_TMO + 1; x_ack = 0; x_err = 1; m_code = 2'b10;
    end
  endtask

  task automatic set_fixed_dat();
    S_DAT0 = 32'hCAFE0000; S_DAT1 = 32'hCAFE0001;
    S_DAT2 = 32'hCAFE0002; S_DAT3 = 32'hCAFE0003;
  endtask

  initial begin
    int x_stb, x_resp, lat, kind;
    logic x_ack, x_err;
    logic [1:0] idx;
    logic [31:0] sd[4];

    tbl[0] = '{2'd2, 2,  1'b1, 1'b0, 3,  4,  1'b1, 1'b0, 32'hCAFE0002, 2'b00};
    tbl[1] = '{2'd3, 0,  1'b1, 1'b0, 0,  1,  1'b0, 1'b1, 32'hCAFE0002, 2'b01};
    tbl[2] = '{2'd1, 99, 1'b1, 1'b0, 16, 17, 1'b0, 1'b1, 32'hCAFE0002, 2'b10};
    tbl[3] = '{2'd0, 0,  1'b1, 1'b1, 1,  2,  1'b0, 1'b1, 32'hCAFE0002, 2'b11};
    tbl[4] = '{2'd0, 0,  1'b1, 1'b0, 1,  2,  1'b1, 1'b0, 32'hCAFE0000, 2'b11};
    tbl[5] = '{2'd1, 15, 1'b1, 1'b0, 16, 17, 1'b1, 1'b0, 32'hCAFE0001, 2'b11};
    tbl[6] = '{2'd2, 1,  1'b0, 1'b1, 2,  3,  1'b0, 1'b1, 32'hCAFE0001, 2'b11};

    RST = 1'b1; M_CYC = 1'b0; M_STB = 1'b0; M_ADR = '0;
    S_ACK = '0; S_ERR = '0; set_fixed_dat();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("reset outputs", {M_ACK, M_ERR, S_STB, SEL, ERR_CODE}, 64'd0);
    chk("reset m_dat", 64'(M_DAT), 64'd0);

    foreach (tbl[i])
      xfer_check($sformatf("vec%0d", i), tbl[i].idx, tbl[i].lat, tbl[i].a, tbl[i].e,
                 tbl[i].stb, tbl[i].resp, tbl[i].ack, tbl[i].err, tbl[i].dat, tbl[i].code);

    // Master abort two cycles into BUSY.
    M_CYC = 1'b1; M_STB = 1'b1; M_ADR = {2'd1, 30'h123};
    @(posedge CLK); @(negedge CLK);
    chk("abort s_stb busy", 64'(S_STB), 64'h2);
    @(posedge CLK); @(negedge CLK);
    M_CYC = 1'b0; M_STB = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("abort s_stb drop", {S_STB, M_ACK, M_ERR}, 64'd0);
    kind = 0;
    repeat (3) begin
      @(posedge CLK); @(negedge CLK);
      if (M_ACK || M_ERR || S_STB != 4'b0) kind++;
    end
    chk("abort quiet", 64'(kind), 64'd0);
    chk("abort m_dat hold", 64'(M_DAT), 64'hCAFE0001);

    // Reset in the middle of a BUSY transfer.
    M_CYC = 1'b1; M_STB = 1'b1; M_ADR = {2'd1, 30'h0};
    repeat (3) begin @(posedge CLK); @(negedge CLK); end
    RST = 1'b1;
    @(posedge CLK); @(negedge CLK);
    RST = 1'b0; M_CYC = 1'b0; M_STB = 1'b0;
    chk("rst mid-busy outputs", {M_ACK, M_ERR, S_STB, SEL, ERR_CODE}, 64'd0);
    chk("rst mid-busy m_dat", 64'(M_DAT), 64'd0);
    xfer_check("post-rst", 2'd2, 1, 1'b1, 1'b0, 2, 3, 1'b1, 1'b0, 32'hCAFE0002, 2'b00);

    m_dat = 32'hCAFE0002; m_code = 2'b00;
    for (int t = 0; t < 40; t++) begin
      foreach (sd[k]) sd[k] = $urandom;
      S_DAT0 = sd[0]; S_DAT1 = sd[1]; S_DAT2 = sd[2]; S_DAT3 = sd[3];
      idx  = 2'($urandom_range(0, 3));
      lat  = $urandom_range(0, 20);
      kind = $urandom_range(0, 3);
      model(idx, lat, kind[0], kind[1], sd[idx], x_stb, x_resp, x_ack, x_err);
      xfer_check($sformatf("rnd%0d", t), idx, lat, kind[0], kind[1],
                 x_stb, x_resp, x_ack, x_err, m_dat, m_code);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
